// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and elaboration-time helpers for the chunked sequential adder.
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Keep the slice index at least one bit wide so CHUNK==WIDTH still elaborates.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for the chunked sequential adder.
interface chunked_seq_adder_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice, reused for every slice of an operation.
module chunked_seq_adder_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  logic carry_s;

  // Bit-serial ripple through the slice.
  always_comb begin
    carry_s = cin_i;
    s_o     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ carry_s;
      carry_s = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry_s;
  end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, carrying between slices in a register.
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_seq_adder_if.slave   bus
);

  localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  typedef logic [IDXW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_sl_s, b_sl_s, s_sl_s;
  logic             c_sl_s;

  // Select the operand slices addressed by the current index.
  always_comb begin
    a_sl_s = '0;
    b_sl_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_sl_s = a_sl_s | ((idx_q == idx_t'(i)) ? a_q[i*CHUNK +: CHUNK] : {CHUNK{1'b0}});
      b_sl_s = b_sl_s | ((idx_q == idx_t'(i)) ? b_q[i*CHUNK +: CHUNK] : {CHUNK{1'b0}});
    end
  end

  chunked_seq_adder_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i    (a_sl_s),
    .b_i    (b_sl_s),
    .cin_i  (carry_q),
    .s_o    (s_sl_s),
    .cout_o (c_sl_s)
  );

  // Next-state and datapath update; b is stored pre-inverted so RUN only ever adds.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          sum_d[i*CHUNK +: CHUNK] = (idx_q == idx_t'(i)) ? s_sl_s : sum_q[i*CHUNK +: CHUNK];
        end
        carry_d = c_sl_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_sl_s;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl_s[CHUNK-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + idx_t'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench: table vectors plus scoreboarded multi-cycle corner sequences.
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(32)) if32 ();
  chunked_seq_adder_if #(.WIDTH(8))  if8w ();
  chunked_seq_adder_if #(.WIDTH(8))  if8n ();

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  chunked_seq_adder #(.WIDTH(8),  .CHUNK(8)) u_dut8w (.clk(clk), .rst_n(rst_n), .bus(if8w));
  chunked_seq_adder #(.WIDTH(8),  .CHUNK(1)) u_dut8n (.clk(clk), .rst_n(rst_n), .bus(if8n));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference from signed/unsigned integer arithmetic.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t   m;
    longint sa, sbv, r;
    logic [63:0] u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sub) begin
      r      = sa - sbv;
      m.cout = (a >= b);
    end else begin
      r      = sa + sbv + longint'(cin);
      u      = 64'(a) + 64'(b) + 64'(cin);
      m.cout = u[32];
    end
    m.sum = r[31:0];
    m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return m;
  endfunction

  // Entered right after the accepting edge; waits for the result and checks it.
  task automatic wait_result(input string nm);
    int   lat;
    res_t e;
    lat = 0;
    @(negedge clk);
    while (!if32.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    e = sb.pop_front();
    chk({nm, "_sum"},  64'(if32.sum),  64'(e.sum));
    chk({nm, "_cout"}, 64'(if32.cout), 64'(e.cout));
    chk({nm, "_ovf"},  64'(if32.ovf),  64'(e.ovf));
    @(negedge clk);
    chk({nm, "_vdrop"}, 64'(if32.out_valid), 64'd0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input res_t exp, input string nm);
    int w;
    w = 0;
    while (!if32.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready"}, 64'(if32.in_ready), 64'd1);
    if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub;
    if32.in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    if32.a = $urandom(); if32.b = $urandom();
    if32.cin = 1'($urandom()); if32.sub = 1'($urandom());
    wait_result(nm);
  endtask

  initial begin
    int   w, lat_w, lat_n;
    res_t e;
    logic [31:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{32'h0000_0001, 32'h0000_000A, 1'b0, 1'b0, 32'h0000_000B, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0;
    if32.out_ready = 1'b1;
    if8w.in_valid = 1'b0; if8w.a = '0; if8w.b = '0; if8w.cin = 1'b0; if8w.sub = 1'b0;
    if8w.out_ready = 1'b1;
    if8n.in_valid = 1'b0; if8n.a = '0; if8n.b = '0; if8n.cin = 1'b0; if8n.sub = 1'b0;
    if8n.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(if32.in_ready),  64'd1);
    chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_sum",       64'(if32.sum),       64'd0);
    chk("rst_cout",      64'(if32.cout),      64'd0);
    chk("rst_ovf",       64'(if32.ovf),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(if32.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      run32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            '{vecs[i].sum, vecs[i].cout, vecs[i].ovf}, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom(); rb = $urandom();
      rc = 1'($urandom()); rs = 1'($urandom());
      run32(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while a new request waits.
    if32.out_ready = 1'b0;
    if32.a = 32'd3; if32.b = 32'd4; if32.cin = 1'b0; if32.sub = 1'b0;
    if32.in_valid = 1'b1;
    sb.push_back(model(32'd3, 32'd4, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    if32.a = 32'd20; if32.b = 32'd22;
    w = 0;
    @(negedge clk);
    while (!if32.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_latency", 64'(w), 64'd4);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_sum%0d", k),      64'(if32.sum),       64'(e.sum));
      chk($sformatf("bp_cout%0d", k),     64'(if32.cout),      64'(e.cout));
      chk($sformatf("bp_ovf%0d", k),      64'(if32.ovf),       64'(e.ovf));
      chk($sformatf("bp_in_ready%0d", k), 64'(if32.in_ready),  64'd0);
      chk($sformatf("bp_valid%0d", k),    64'(if32.out_valid), 64'd1);
      @(negedge clk);
    end
    sb.push_back(model(32'd20, 32'd22, 1'b0, 1'b0));
    if32.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", 64'(if32.out_valid), 64'd0);
    chk("bp_idle_ready", 64'(if32.in_ready),  64'd1);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    wait_result("bp_next");

    // Reset two cycles into an operation discards it.
    if32.a = 32'h1111_1111; if32.b = 32'h2222_2222; if32.sub = 1'b0; if32.cin = 1'b0;
    if32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(if32.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("mid_rst_sum",       64'(if32.sum),       64'd0);
    chk("mid_rst_cout",      64'(if32.cout),      64'd0);
    chk("mid_rst_ovf",       64'(if32.ovf),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run32(32'd100, 32'd155, 1'b0, 1'b0, '{32'd255, 1'b0, 1'b0}, "after_rst");

    // 8-bit variants: one slice versus eight single-bit slices.
    if8w.a = 8'd100; if8w.b = 8'd200; if8w.in_valid = 1'b1;
    if8n.a = 8'd100; if8n.b = 8'd200; if8n.in_valid = 1'b1;
    chk("w8_ready", 64'(if8w.in_ready), 64'd1);
    chk("n8_ready", 64'(if8n.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if8w.in_valid = 1'b0; if8w.a = 8'd0; if8w.b = 8'd0;
    if8n.in_valid = 1'b0; if8n.a = 8'd0; if8n.b = 8'd0;
    lat_w = -1;
    lat_n = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lat_w < 0 && if8w.out_valid) begin
        lat_w = c;
        chk("w8_sum",  64'(if8w.sum),  64'd44);
        chk("w8_cout", 64'(if8w.cout), 64'd1);
        chk("w8_ovf",  64'(if8w.ovf),  64'd0);
      end
      if (lat_n < 0 && if8n.out_valid) begin
        lat_n = c;
        chk("n8_sum",  64'(if8n.sum),  64'd44);
        chk("n8_cout", 64'(if8n.cout), 64'd1);
        chk("n8_ovf",  64'(if8n.ovf),  64'd0);
      end
    end
    chk("w8_latency", 64'(lat_w), 64'd1);
    chk("n8_latency", 64'(lat_n), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
